// File: rtl/fetch_decode_queue.sv
// Purpose: fetch->decode instruction buffer, DEPTH-entry FIFO of {PC, instr}, dropped on branch flush.
// Latency: an entry written at edge k is visible at the head after edge k (no same-cycle bypass).
// Backpressure: enq_ready_F low only when full (a same-cycle dequeue does not free a slot); decode stalls via deq_ready_D.
//
// Ports:
//   clk, reset (async, active-low)
//   enq_valid_F/enq_ready_F, imem_addr_F, imem_data_F : fetch-side handshake and entry
//   deq_valid_D/deq_ready_D, pc_D, instr_D            : decode-side handshake and head entry (zero when empty)
//   flush_D                                           : taken branch, drops every entry
//   count_D                                           : number of occupied entries
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int N     = 64,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid_F,
  input  logic [N-1:0]             imem_addr_F,
  input  logic [W-1:0]             imem_data_F,
  output logic                     enq_ready_F,
  output logic                     deq_valid_D,
  input  logic                     deq_ready_D,
  output logic [N-1:0]             pc_D,
  output logic [W-1:0]             instr_D,
  input  logic                     flush_D,
  output logic [$clog2(DEPTH):0]   count_D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          enq_fire;
  logic          deq_fire;

  // Full/empty come from the registered count only, so the pointers can wrap freely.
  assign enq_ready_F = (count_D != CW'(DEPTH));
  assign deq_valid_D = (count_D != '0);
  assign enq_fire    = enq_valid_F & enq_ready_F;
  assign deq_fire    = deq_valid_D & deq_ready_D;

  // Head is forced to zero when empty so decode never sees stale storage.
  assign pc_D    = deq_valid_D ? pc_mem[rd_ptr]    : '0;
  assign instr_D = deq_valid_D ? instr_mem[rd_ptr] : '0;

  // Storage needs no reset; occupancy is tracked solely by count_D.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush_D) begin
      pc_mem[wr_ptr]    <= imem_addr_F;
      instr_mem[wr_ptr] <= imem_data_F;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_D <= '0;
    end else if (flush_D) begin
      // Flush wins: the concurrent enqueue is dropped and the dequeue is not counted.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_D <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_D <= count_D + 1'b1;
        2'b01:   count_D <= count_D - 1'b1;
        default: count_D <= count_D;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int N     = 64;
  localparam int W     = 32;

  logic          clk;
  logic          reset;
  logic          enq_valid_F;
  logic [N-1:0]  imem_addr_F;
  logic [W-1:0]  imem_data_F;
  logic          enq_ready_F;
  logic          deq_valid_D;
  logic          deq_ready_D;
  logic [N-1:0]  pc_D;
  logic [W-1:0]  instr_D;
  logic          flush_D;
  logic [2:0]    count_D;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .N(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enq_valid_F (enq_valid_F),
    .imem_addr_F (imem_addr_F),
    .imem_data_F (imem_data_F),
    .enq_ready_F (enq_ready_F),
    .deq_valid_D (deq_valid_D),
    .deq_ready_D (deq_ready_D),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .flush_D     (flush_D),
    .count_D     (count_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of {pc, instr} updated with the handshake rules.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];

  always @(negedge reset) q.delete();

  always @(posedge clk) begin
    bit e, d;
    if (!reset) begin
      q.delete();
    end else begin
      e = enq_valid_F && (q.size() != DEPTH);
      d = deq_ready_D && (q.size() != 0);
      if (flush_D) begin
        q.delete();
      end else begin
        if (d) void'(q.pop_front());
        if (e) q.push_back('{pc: imem_addr_F, ins: imem_data_F});
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("cmp_count", 64'(count_D), 64'(q.size()));
      chk("cmp_deq_valid", 64'(deq_valid_D), 64'(q.size() != 0));
      chk("cmp_enq_ready", 64'(enq_ready_F), 64'(q.size() != DEPTH));
      chk("cmp_pc", pc_D, (q.size() != 0) ? q[0].pc : 64'h0);
      chk("cmp_instr", 64'(instr_D), (q.size() != 0) ? 64'(q[0].ins) : 64'h0);
    end
  end

  // Apply one cycle of inputs, return 1ns after the rising edge.
  task automatic step(input logic ev, input logic [63:0] a, input logic [31:0] dat,
                      input logic dr, input logic fl);
    enq_valid_F = ev;
    imem_addr_F = a;
    imem_data_F = dat;
    deq_ready_D = dr;
    flush_D     = fl;
    @(posedge clk);
    #1;
    enq_valid_F = 1'b0;
    deq_ready_D = 1'b0;
    flush_D     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    enq_valid_F = 1'b0;
    imem_addr_F = '0;
    imem_data_F = '0;
    deq_ready_D = 1'b0;
    flush_D     = 1'b0;

    // 1. Reset values
    #2;
    chk("rst_count", 64'(count_D), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid_D), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready_F), 64'd1);
    chk("rst_pc", pc_D, 64'd0);
    chk("rst_instr", 64'(instr_D), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 2. Fill to full, then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 32'(8'hA0 + i), 1'b0, 1'b0);
    chk("fill_count", 64'(count_D), 64'd4);
    chk("fill_enq_ready", 64'(enq_ready_F), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pc_D, 64'(i * 4));
      chk("drain_instr", 64'(instr_D), 64'(8'hA0 + i));
      step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_deq_valid", 64'(deq_valid_D), 64'd0);
    chk("drain_pc_zero", pc_D, 64'd0);

    // 3. Full with simultaneous enqueue offer and dequeue: only the dequeue happens
    for (int i = 0; i < 4; i++) step(1'b1, 64'(16 + i * 4), 32'(8'hB0 + i), 1'b0, 1'b0);
    step(1'b1, 64'h999, 32'hBAD, 1'b1, 1'b0);
    chk("full_both_count", 64'(count_D), 64'd3);
    chk("full_both_head", pc_D, 64'h14);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    chk("full_both_last", pc_D, 64'h1C);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    chk("full_both_empty", 64'(deq_valid_D), 64'd0);

    // 4. Steady-state enq+deq at count 2, pointers wrap
    step(1'b1, 64'h200, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 64'h204, 32'hD1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", pc_D, 64'(32'h200 + 4 * i));
      step(1'b1, 64'(32'h208 + 4 * i), 32'(8'hD2 + i), 1'b1, 1'b0);
      chk("stream_count", 64'(count_D), 64'd2);
    end
    chk("stream_final_head", pc_D, 64'h228);
    chk("stream_final_instr", 64'(instr_D), 64'hDA);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // 5. Flush at count 3 with enq and deq offered
    for (int i = 0; i < 3; i++) step(1'b1, 64'(32'h300 + 4 * i), 32'(8'hE0 + i), 1'b0, 1'b0);
    chk("preflush_count", 64'(count_D), 64'd3);
    step(1'b1, 64'h30C, 32'hE3, 1'b1, 1'b1);
    chk("flush_count", 64'(count_D), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid_D), 64'd0);
    chk("flush_pc", pc_D, 64'd0);
    step(1'b1, 64'h100, 32'hC0, 1'b0, 1'b0);
    chk("postflush_count", 64'(count_D), 64'd1);
    chk("postflush_pc", pc_D, 64'h100);
    chk("postflush_instr", 64'(instr_D), 64'hC0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    chk("flush_empty_count", 64'(count_D), 64'd0);
    chk("flush_empty_ready", 64'(enq_ready_F), 64'd1);

    // 6. Asynchronous reset mid-stream at count 2
    step(1'b1, 64'h400, 32'hF0, 1'b0, 1'b0);
    step(1'b1, 64'h404, 32'hF1, 1'b0, 1'b0);
    chk("prerst_count", 64'(count_D), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 64'(count_D), 64'd0);
    chk("arst_deq_valid", 64'(deq_valid_D), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready_F), 64'd1);
    chk("arst_pc", pc_D, 64'd0);
    chk("arst_instr", 64'(instr_D), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 64'h500, 32'h55, 1'b0, 1'b0);
    chk("postrst_pc", pc_D, 64'h500);
    chk("postrst_count", 64'(count_D), 64'd1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
